rf_wr_arbiter: RTL and testbench

Write-port arbiter for the 32x32 register file, which has a single write port. It shares that port between the in-order pipeline writeback (port A, cannot be back-pressured) and the long-latency multiply/divide unit (port B, valid/ready). Port B results are buffered in a small FIFO and drained into idle write-port cycles. Guarantees: last-writer-wins ordering; a pending-write query for hazard detection; forced pipeline stall on starvation.

---
 rtl/rf_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Single write-port arbiter for the 32x32 register file: pipeline writeback always wins,
// mul/div results queue in a small FIFO and drain into free cycles, with a forced stall on starvation.
//
// state | meaning
// IDLE  | FIFO empty, nothing to drain
// DRAIN | FIFO holds entries, head drains whenever the port is free
// FORCE | head starved too long, pipeline stalled so the head can write
module rf_wr_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_stall,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic [4:0]  q_addr1,
   input  logic [4:0]  q_addr2,
   output logic        q_pend1,
   output logic        q_pend2
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FORCE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     starve_cnt, starve_cnt_nxt;
   logic [4:0]     fifo_addr [DEPTH];
   logic [31:0]    fifo_data [DEPTH];
   logic [DEPTH-1:0] fifo_live;
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count, count_nxt;
   logic           a_write, head_live, enq, pop, blocked;

   assign a_write   = a_valid && (a_addr != 5'd0);
   assign head_live = (count != '0) && fifo_live[rd_ptr];
   assign b_ready   = !reset && (count < DEPTH_C);
   assign enq       = b_valid && b_ready;
   // a dead head leaves even while A owns the port; a live one waits for a free cycle
   assign pop       = (count != '0) && (!fifo_live[rd_ptr] || !a_write);
   assign blocked   = head_live && a_write;

   assign rf_we    = !reset && (a_write || head_live);
   assign rf_waddr = a_write ? a_addr : fifo_addr[rd_ptr];
   assign rf_wdata = a_write ? a_data : fifo_data[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({enq, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_ptr] <= b_addr;
         fifo_data[wr_ptr] <= b_data;
      end
   end

   // live bits of free slots are kept at 0 so the hazard query needs no valid mask
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         fifo_live <= '0;
      end else begin
         if (a_write) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (fifo_addr[i] == a_addr) fifo_live[i] <= 1'b0;
            end
         end
         if (pop) begin
            fifo_live[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (enq) begin
            fifo_live[wr_ptr] <= (b_addr != 5'd0) && !(a_write && (a_addr == b_addr));
            wr_ptr            <= wr_ptr + PW'(1);
         end
         count <= count_nxt;
      end
   end

   always_comb begin
      q_pend1 = 1'b0;
      q_pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_live[i] && (fifo_addr[i] == q_addr1) && (q_addr1 != 5'd0)) q_pend1 = 1'b1;
         if (fifo_live[i] && (fifo_addr[i] == q_addr2) && (q_addr2 != 5'd0)) q_pend2 = 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      case (state)
         ST_IDLE: begin
            starve_cnt_nxt = '0;
            if (enq) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (count_nxt == '0) begin
               state_nxt      = ST_IDLE;
               starve_cnt_nxt = '0;
            end else if (pop) begin
               starve_cnt_nxt = '0;
            end else if (blocked) begin
               starve_cnt_nxt = starve_cnt + 4'd1;
               if (starve_cnt_nxt >= LIMIT_C) state_nxt = ST_FORCE;
            end
         end
         ST_FORCE: begin
            // a misbehaving pipeline write still wins; keep stalling until a free cycle
            if (!a_write) begin
               starve_cnt_nxt = '0;
               state_nxt      = (count_nxt != '0) ? ST_DRAIN : ST_IDLE;
            end
         end
         default: begin
            state_nxt      = ST_IDLE;
            starve_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         a_stall    <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
         a_stall    <= (state_nxt == ST_FORCE);
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus random traffic checked against a
// queue-based reference model and a shadow register file.
module tb_rf_wr_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, a_stall, b_valid, b_ready, rf_we, q_pend1, q_pend2;
   logic [4:0]  a_addr, b_addr, rf_waddr, q_addr1, q_addr2;
   logic [31:0] a_data, b_data, rf_wdata;

   always #5 clk = ~clk;

   rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t        mq[$];
   int          m_blk = 0;
   bit          m_frc = 1'b0;
   bit          m_bready = 1'b0;
   logic [31:0] m_rf [32];
   logic [31:0] rf_dut [32];
   int          wcnt [32];
   int          errors = 0;
   int          checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic [4:0] q1, input logic [4:0] q2);
      bit          aw, hl, ewe, enq, pop, blocked, p1, p2, dwe;
      logic [4:0]  ewa, dwa;
      logic [31:0] ewd, dwd;
      reset = r; a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd; q_addr1 = q1; q_addr2 = q2;
      @(negedge clk);
      aw  = av && (aa != 5'd0);
      hl  = (mq.size() > 0) && mq[0].live;
      ewe = 1'b0; ewa = '0; ewd = '0;
      if (r) begin
         m_bready = 1'b0;
         check_val("we_in_reset", 32'(rf_we), 32'd0);
         check_val("bready_in_reset", 32'(b_ready), 32'd0);
      end else begin
         m_bready = mq.size() < DEPTH;
         ewe = aw || hl;
         ewa = aw ? aa : (hl ? mq[0].addr : 5'd0);
         ewd = aw ? ad : (hl ? mq[0].data : 32'd0);
         p1 = 1'b0; p2 = 1'b0;
         foreach (mq[i]) begin
            if (mq[i].live && mq[i].addr == q1 && q1 != 5'd0) p1 = 1'b1;
            if (mq[i].live && mq[i].addr == q2 && q2 != 5'd0) p2 = 1'b1;
         end
         check_val("rf_we", 32'(rf_we), 32'(ewe));
         if (ewe) begin
            check_val("rf_waddr", 32'(rf_waddr), 32'(ewa));
            check_val("rf_wdata", rf_wdata, ewd);
         end
         check_val("b_ready", 32'(b_ready), 32'(m_bready));
         check_val("a_stall", 32'(a_stall), 32'(m_frc));
         check_val("q_pend1", 32'(q_pend1), 32'(p1));
         check_val("q_pend2", 32'(q_pend2), 32'(p2));
      end
      dwe = rf_we; dwa = rf_waddr; dwd = rf_wdata;
      @(posedge clk);
      if (dwe) begin
         rf_dut[dwa] = dwd;
         wcnt[dwa]++;
      end
      if (r) begin
         mq.delete();
         m_blk = 0;
         m_frc = 1'b0;
      end else begin
         if (ewe) m_rf[ewa] = ewd;
         enq     = bv && m_bready;
         pop     = (mq.size() > 0) && (!mq[0].live || !aw);
         blocked = hl && aw;
         if (aw) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
         if (pop) void'(mq.pop_front());
         if (enq) mq.push_back('{addr: ba, data: bd, live: (ba != 5'd0) && !(aw && aa == ba)});
         if (m_frc) begin
            if (!aw) begin
               m_frc = 1'b0;
               m_blk = 0;
            end
         end else if (pop) begin
            m_blk = 0;
         end else if (blocked) begin
            m_blk++;
            if (m_blk >= LIMIT) m_frc = 1'b1;
         end
         if (mq.size() == 0 && !m_frc) m_blk = 0;
      end
      #1;
   endtask

   task automatic idle(input int n, input logic [4:0] q1);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, q1, 0);
   endtask

   bit          pend_b;
   logic [4:0]  pb_addr;
   logic [31:0] pb_data;

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_dut[i] = '0; m_rf[i] = '0; wcnt[i] = 0;
      end
      reset = 1'b1; a_valid = 0; a_addr = 0; a_data = 0;
      b_valid = 0; b_addr = 0; b_data = 0; q_addr1 = 0; q_addr2 = 0;
      repeat (2) @(posedge clk);
      #1;

      // reset holds the port even with a pipeline write presented
      cycle(1, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
      idle(1, 5'd3);

      // B alone
      cycle(0, 0, 0, 0, 1, 5'd5, 32'h1234, 5'd5, 0);
      check_val("b_alone_pend", 32'(q_pend1), 32'd1);
      idle(2, 5'd5);
      check_val("b_alone_r5", rf_dut[5], 32'h1234);

      // kill ordering
      cycle(0, 0, 0, 0, 1, 5'd7, 32'hAAAA, 5'd7, 0);
      cycle(0, 1, 5'd7, 32'hBBBB, 0, 0, 0, 5'd7, 5'd7);
      idle(3, 5'd7);
      check_val("kill_r7", rf_dut[7], 32'hBBBB);
      check_val("kill_r7_writes", 32'(wcnt[7]), 32'd1);

      // same-cycle collision
      cycle(0, 1, 5'd9, 32'h2, 1, 5'd9, 32'h1, 5'd9, 0);
      idle(3, 5'd9);
      check_val("coll_r9", rf_dut[9], 32'h2);
      check_val("coll_r9_writes", 32'(wcnt[9]), 32'd1);

      // full FIFO with A busy; third result held until space frees
      cycle(0, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA10, 5'd10, 5'd11);
      cycle(0, 1, 5'd2, 32'h22, 1, 5'd11, 32'hA11, 5'd10, 5'd11);
      check_val("full_bready", 32'(b_ready), 32'd0);
      cycle(0, 1, 5'd3, 32'h33, 1, 5'd12, 32'hA12, 5'd10, 5'd12);
      cycle(0, 1, 5'd4, 32'h44, 1, 5'd12, 32'hA12, 5'd10, 5'd12);
      cycle(0, 0, 0, 0, 1, 5'd12, 32'hA12, 5'd11, 5'd12);
      check_val("space_bready", 32'(b_ready), 32'd1);
      cycle(0, 0, 0, 0, 1, 5'd12, 32'hA12, 5'd11, 5'd12);
      idle(3, 5'd12);
      check_val("full_r10", rf_dut[10], 32'hA10);
      check_val("full_r11", rf_dut[11], 32'hA11);
      check_val("full_r12", rf_dut[12], 32'hA12);

      // starvation: four blocked cycles, then one stall cycle
      cycle(0, 1, 5'd1, 32'h101, 1, 5'd13, 32'hD, 5'd13, 0);
      for (int i = 0; i < 6; i++) begin
         check_val("stall_seq", 32'(a_stall), 32'(i == 4));
         cycle(0, i != 4, 5'd2, 32'(i), 0, 0, 0, 5'd13, 0);
      end
      check_val("starve_r13", rf_dut[13], 32'hD);

      // r0 result never writes; reset discards two live entries
      cycle(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0);
      idle(2, 0);
      check_val("r0_writes", 32'(wcnt[0]), 32'd0);
      cycle(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 5'd20, 5'd21);
      cycle(0, 1, 5'd2, 32'h2, 1, 5'd21, 32'h21, 5'd20, 5'd21);
      cycle(1, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
      idle(3, 5'd20);
      check_val("rst_r20_writes", 32'(wcnt[20]), 32'd0);
      check_val("rst_r21_writes", 32'(wcnt[21]), 32'd0);

      // random traffic, small address range for frequent collisions
      pend_b = 1'b0; pb_addr = '0; pb_data = '0;
      for (int n = 0; n < 600; n++) begin
         bit          rr, av;
         logic [4:0]  aa;
         rr = ($urandom_range(149, 0) == 0);
         av = !m_frc && ($urandom_range(2, 0) != 0);
         aa = 5'($urandom_range(7, 0));
         if (!pend_b && $urandom_range(1, 0) == 1) begin
            pend_b  = 1'b1;
            pb_addr = 5'($urandom_range(7, 0));
            pb_data = $urandom;
         end
         cycle(rr, av, aa, $urandom, pend_b, pb_addr, pb_data,
               5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
         if (pend_b && m_bready && !rr) pend_b = 1'b0;
      end
      idle(8, 0);
      for (int i = 0; i < 32; i++) check_val($sformatf("rf_r%0d", i), rf_dut[i], m_rf[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
